// File: rtl/bram_arb_pkg.sv
// ----------------------------------------------------------------------------
// bram_arb_pkg
// Shared definitions for the two-requester block-RAM arbiter.
//   state_t  : arbiter FSM states (IDLE -> ACCESS -> [RDATA] -> IDLE)
//   NUM_REQ  : number of requesters sharing the RAM
//   DATA_W   : RAM word width in bits
//   BE_W     : number of byte enables per word
// ----------------------------------------------------------------------------
package bram_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

endpackage

// File: rtl/bram_arb_pick.sv
// ----------------------------------------------------------------------------
// bram_arb_pick
// Combinational winner selection for the BRAM arbiter.
//   req[1:0]    : pending requests (bit n = requester n)
//   last_winner : index of the requester granted most recently
//   winner[1:0] : one-hot winner, all zero when nobody requests
//
// Configuration macro: BRAM_ARB_RR_EN
//   defined   -> round-robin, the requester that did not win last time wins
//                a tie
//   undefined -> fixed priority, requester 0 always wins a tie and
//                last_winner is ignored (its register is trimmed away)
// ----------------------------------------------------------------------------
module bram_arb_pick
    import bram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_winner,
    output logic [NUM_REQ-1:0] winner
);

`ifdef BRAM_ARB_RR_EN
    // On a tie hand the RAM to whoever did not have it last time; a lone
    // request simply wins.
    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = last_winner ? 2'b01 : 2'b10;
        end
    end
`else
    // Requester 0 (CPU bus) outranks the loader whenever both ask.
    always_comb begin
        winner = 2'b00;
        if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
    end

    logic unused_last_winner;
    assign unused_last_winner = last_winner;
`endif

endmodule

// File: rtl/bram_arbiter.sv
// ----------------------------------------------------------------------------
// bram_arbiter
// Shares one simple-dual-port block RAM (port A write, port B read, both on
// clk) between a CPU-bus requester (0) and a loader/DMA requester (1).
// One access at a time: a write takes 2 cycles, a read 3 cycles.
//
// Ports
//   clk, RSTn                  : clock, async active-low reset
//   reqN, weN, addrN, wdataN,  : request, write flag, word address, write
//   beN                          data and byte enables from requester N
//   gntN                       : one-cycle grant pulse (the ACCESS cycle)
//   rvalidN, rdataN            : one-cycle read-data-valid pulse and data
//   ram_addra, ram_dina,       : RAM write port
//   ram_wea
//   ram_addrb, ram_doutb       : RAM read port (doutb registered in the RAM)
//   busy                       : high whenever the arbiter is not IDLE
//
// Configuration macro: BRAM_ARB_RR_EN (round-robin instead of fixed priority,
// acts only inside bram_arb_pick).
// ----------------------------------------------------------------------------
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [BE_W-1:0]       be0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [BE_W-1:0]       be1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [DATA_W-1:0]     ram_dina,
    output logic [BE_W-1:0]       ram_wea,
    input  logic [DATA_W-1:0]     ram_doutb,
    output logic                  busy
);

    state_t                state;
    logic                  owner;
    logic                  last_winner;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [NUM_REQ-1:0]    winner;

    bram_arb_pick u_pick (
        .req         ({req1, req0}),
        .last_winner (last_winner),
        .winner      (winner)
    );

    // Main FSM. The winner's payload is captured in IDLE so the requester may
    // drop req as soon as it sees its grant; grant and rvalid are registered
    // pulses that line up with the ACCESS and RDATA cycles.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (|winner) begin
                        state       <= ACCESS;
                        owner       <= winner[1];
                        last_winner <= winner[1];
                        we_q        <= winner[1] ? we1    : we0;
                        addr_q      <= winner[1] ? addr1  : addr0;
                        wdata_q     <= winner[1] ? wdata1 : wdata0;
                        be_q        <= winner[1] ? be1    : be0;
                        gnt0        <= winner[0];
                        gnt1        <= winner[1];
                    end
                end
                ACCESS: begin
                    // The RAM registers the read address this cycle, so the
                    // data shows up on ram_doutb during RDATA.
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        state   <= RDATA;
                        rvalid0 <= ~owner;
                        rvalid1 <= owner;
                    end
                end
                RDATA: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes derive from the state register so an async reset in the middle
    // of ACCESS kills the write before the next clock edge.
    always_comb begin
        ram_wea = '0;
        if (state == ACCESS && we_q) begin
            ram_wea = be_q;
        end
    end

    assign ram_addra = addr_q;
    assign ram_addrb = addr_q;
    assign ram_dina  = wdata_q;
    assign busy      = (state != IDLE);
    assign rdata0    = rvalid0 ? ram_doutb : '0;
    assign rdata1    = rvalid1 ? ram_doutb : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_arbiter
// Bench for bram_arbiter with a behavioural RAM and a transaction-level model.
// The model tracks when the arbiter is free, picks winners from the
// arbitration rules, and schedules the expected grant, strobe, busy and
// read-data cycles by latency arithmetic. Honours BRAM_ARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          RSTn = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic [3:0]    be0 = '0, be1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [31:0]   rdata0, rdata1, ram_dina;
    logic [31:0]   ram_doutb = '0;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [3:0]    ram_wea;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .RSTn(RSTn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina),
        .ram_wea(ram_wea), .ram_doutb(ram_doutb), .busy(busy)
    );

    // Block RAM driven by the DUT: byte-enabled write on A, registered read on B.
    logic [31:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wea[b]) ram_mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
        end
        ram_doutb <= ram_mem[ram_addrb];
    end

    // Model state
    logic [31:0]   mdl_mem [0:(1<<AW)-1];
    bit            e_gnt0 [8], e_gnt1 [8], e_rv0 [8], e_rv1 [8], e_busy [8], e_achk [8];
    logic [3:0]    e_wea [8];
    logic [AW-1:0] e_addr [8], e_raddr [8];
    int            cyc = 0, next_idle = 0;
    bit            last_win = 1'b1;
    bit            pw_valid = 1'b0;
    int            pw_cyc = 0;
    logic [AW-1:0] pw_addr;
    logic [31:0]   pw_data;
    logic [3:0]    pw_be;
    bit            pend0 = 1'b0, pend1 = 1'b0, hold_mode = 1'b0;
    int            checks = 0, errors = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clearSlot(input int s);
        e_gnt0[s] = 0; e_gnt1[s] = 0; e_rv0[s] = 0; e_rv1[s] = 0;
        e_busy[s] = 0; e_achk[s] = 0; e_wea[s] = '0; e_addr[s] = '0; e_raddr[s] = '0;
    endtask

    task automatic modelReset();
        for (int s = 0; s < 8; s++) clearSlot(s);
        pw_valid  = 0;
        next_idle = 0;
        last_win  = 1'b1;
        req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
    endtask

    // Runs just before the edge that ends cycle 'cyc'.
    task automatic modelSample();
        int w, s1, s2;
        if (pw_valid && pw_cyc == cyc) begin
            if (RSTn) begin
                for (int b = 0; b < 4; b++) begin
                    if (pw_be[b]) mdl_mem[pw_addr][b*8 +: 8] = pw_data[b*8 +: 8];
                end
            end
            pw_valid = 0;
        end
        if (RSTn && cyc >= next_idle && (req0 || req1)) begin
`ifdef BRAM_ARB_RR_EN
            if (req0 && req1) w = last_win ? 0 : 1;
            else              w = req0 ? 0 : 1;
`else
            w = req0 ? 0 : 1;
`endif
            last_win = w[0];
            s1 = (cyc + 1) % 8;
            s2 = (cyc + 2) % 8;
            e_gnt0[s1] = (w == 0);
            e_gnt1[s1] = (w == 1);
            e_busy[s1] = 1;
            e_achk[s1] = 1;
            e_addr[s1] = (w == 0) ? addr0 : addr1;
            if ((w == 0) ? we0 : we1) begin
                e_wea[s1] = (w == 0) ? be0 : be1;
                pw_valid  = 1;
                pw_cyc    = cyc + 1;
                pw_addr   = (w == 0) ? addr0 : addr1;
                pw_data   = (w == 0) ? wdata0 : wdata1;
                pw_be     = (w == 0) ? be0 : be1;
                next_idle = cyc + 2;
            end else begin
                e_busy[s2]  = 1;
                e_rv0[s2]   = (w == 0);
                e_rv1[s2]   = (w == 1);
                e_raddr[s2] = (w == 0) ? addr0 : addr1;
                next_idle   = cyc + 3;
            end
        end
    endtask

    task automatic checkOutput();
        int s;
        s = cyc % 8;
        checkVal("gnt0", 32'(gnt0), 32'(e_gnt0[s]));
        checkVal("gnt1", 32'(gnt1), 32'(e_gnt1[s]));
        checkVal("rvalid0", 32'(rvalid0), 32'(e_rv0[s]));
        checkVal("rvalid1", 32'(rvalid1), 32'(e_rv1[s]));
        checkVal("busy", 32'(busy), 32'(e_busy[s]));
        checkVal("ram_wea", 32'(ram_wea), 32'(e_wea[s]));
        if (e_achk[s]) checkVal("ram_addra", 32'(ram_addra), 32'(e_addr[s]));
        if (e_rv0[s]) checkVal("rdata0", rdata0, mdl_mem[e_raddr[s]]);
        if (e_rv1[s]) checkVal("rdata1", rdata1, mdl_mem[e_raddr[s]]);
        clearSlot(s);
    endtask

    task automatic tick();
        modelSample();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
        if (!hold_mode) begin
            if (gnt0) begin req0 = 0; pend0 = 0; end
            if (gnt1) begin req1 = 0; pend1 = 0; end
        end
    endtask

    task automatic issue(input int who, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        if (who == 0) begin
            req0 = 1; we0 = we; addr0 = addr; wdata0 = data; be0 = be; pend0 = 1;
        end else begin
            req1 = 1; we1 = we; addr1 = addr; wdata1 = data; be1 = be; pend1 = 1;
        end
    endtask

    task automatic doWrite(input int who, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
        issue(who, 1'b1, addr, data, be);
        tick();
        tick();
    endtask

    task automatic doRead(input int who, input logic [AW-1:0] addr,
                          output logic [31:0] data, output logic rv);
        issue(who, 1'b0, addr, 32'h0, 4'h0);
        tick();
        tick();
        rv   = (who == 0) ? rvalid0 : rvalid1;
        data = (who == 0) ? rdata0 : rdata1;
        tick();
    endtask

    task automatic doReset();
        RSTn = 0;
        modelReset();
        #1;
        checkVal("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        RSTn = 1;
    endtask

    task automatic applyStimulus();
        if (!pend0 && $urandom_range(0, 2) == 0)
            issue(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)));
        if (!pend1 && $urandom_range(0, 2) == 0)
            issue(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [31:0] rd;
        logic        rv;
        int          grant_q[$];
        int          exp_seq[4];

        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        #2;
        doReset();
        checkVal("reset_wea", 32'(ram_wea), 32'h0);

        // Write then read-back after reset
        issue(0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
        tick();
        checkVal("wr_gnt0", 32'(gnt0), 32'h1);
        checkVal("wr_wea", 32'(ram_wea), 32'hF);
        tick();
        checkVal("wr_busy_done", 32'(busy), 32'h0);
        doRead(0, 14'h0010, rd, rv);
        checkVal("rd_rvalid0", 32'(rv), 32'h1);
        checkVal("rd_rdata0", rd, 32'hDEADBEEF);

        // Byte-enabled write merge
        doWrite(0, 14'h0030, 32'h11223344, 4'hF);
        doWrite(1, 14'h0030, 32'hAABBCCDD, 4'b0101);
        doRead(0, 14'h0030, rd, rv);
        checkVal("byte_merge", rd, 32'h11BB33DD);

        // Zero byte-enable write leaves the word alone
        doWrite(1, 14'h0040, 32'h55667788, 4'hF);
        doWrite(0, 14'h0040, 32'hFFFFFFFF, 4'h0);
        doRead(1, 14'h0040, rd, rv);
        checkVal("be_zero_keep", rd, 32'h55667788);

        // Reset during the ACCESS cycle of a write
        doWrite(0, 14'h0020, 32'h12345678, 4'hF);
        issue(0, 1'b1, 14'h0020, 32'hCAFEF00D, 4'hF);
        tick();
        checkVal("mid_gnt0_before", 32'(gnt0), 32'h1);
        RSTn = 0;
        modelReset();
        #1;
        checkVal("mid_gnt0_cleared", 32'(gnt0), 32'h0);
        checkVal("mid_wea_cleared", 32'(ram_wea), 32'h0);
        checkVal("mid_busy_cleared", 32'(busy), 32'h0);
        tick();
        checkVal("mid_no_rvalid", 32'(rvalid0), 32'h0);
        tick();
        RSTn = 1;
        tick();
        checkVal("post_rst_idle", 32'(busy), 32'h0);
        doRead(0, 14'h0020, rd, rv);
        checkVal("mid_old_value", rd, 32'h12345678);

        // Contention with both requests held high
        doReset();
        hold_mode = 1;
        issue(0, 1'b1, 14'h0050, 32'h00000050, 4'hF);
        issue(1, 1'b1, 14'h0051, 32'h00000051, 4'hF);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt0) grant_q.push_back(0);
            if (gnt1) grant_q.push_back(1);
        end
        hold_mode = 0;
        req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
`ifdef BRAM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        checkVal("cont_grants", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkVal("cont_order", (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFFFFFF,
                     32'(exp_seq[i]));
        end
        tick();

        // Late request from requester 1 during requester 0's ACCESS
        issue(0, 1'b0, 14'h0010, 32'h0, 4'h0);
        tick();
        checkVal("late_gnt0", 32'(gnt0), 32'h1);
        issue(1, 1'b0, 14'h0030, 32'h0, 4'h0);
        tick();
        checkVal("late_rdata0", rdata0, 32'hDEADBEEF);
        checkVal("late_gnt1_early", 32'(gnt1), 32'h0);
        tick();
        checkVal("late_idle_gnt1", 32'(gnt1), 32'h0);
        checkVal("late_idle_gnt0", 32'(gnt0), 32'h0);
        tick();
        checkVal("late_gnt1", 32'(gnt1), 32'h1);
        checkVal("late_no_dup_gnt0", 32'(gnt0), 32'h0);
        tick();
        checkVal("late_rvalid1", 32'(rvalid1), 32'h1);
        checkVal("late_rdata1", rdata1, 32'h11BB33DD);
        tick();

        // Randomized traffic on a small address window
        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            tick();
        end
        for (int i = 0; i < 12; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, sets the word address width of both requesters and the RAM.
REQ-002 clk  input  1  single clock for all state; RAM shares this clock.
REQ-003 RSTn  input  1  reset, asynchronous assert, active-low.
REQ-004 req0/req1  input  1  access request from requester 0 (CPU bus) / requester 1 (loader/DMA).
REQ-005 we0/we1  input  1  1 = write, 0 = read.
REQ-006 addr0/addr1  input  ADDR_WIDTH  word address.
REQ-007 wdata0/wdata1  input  32  write data.
REQ-008 be0/be1  input  4  byte enables; bit n covers byte n.
REQ-009 gnt0/gnt1  output  1  one-cycle grant pulse.
REQ-010 rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-011 rdata0/rdata1  output  32  read data, meaningful only while the matching rvalid is high.
REQ-012 ram_addra/ram_addrb  output  ADDR_WIDTH  RAM write/read addresses.
REQ-013 ram_dina  output  32  RAM write data.
REQ-014 ram_wea  output  4  RAM byte write strobes.
REQ-015 ram_doutb  input  32  RAM read data, registered in the RAM, valid one clock after the address.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS and RDATA.
REQ-018 IDLE: if any req is high, at the clock edge select a winner, latch its we/addr/wdata/be, record it as owner, and move to ACCESS.
REQ-019 gnt<owner> SHALL be registered and high exactly during the ACCESS cycle; the other gnt stays 0.
REQ-020 ACCESS: ram_addra = ram_addrb = latched addr and ram_dina = latched wdata.
- Write: ram_wea = latched be.
- Read: ram_wea = 0.
REQ-021 ram_wea SHALL be 4'b0000 in every state other than ACCESS-with-write.
REQ-022 ACCESS-write moves to IDLE; ACCESS-read moves to RDATA.
REQ-023 RDATA: rvalid<owner> = 1 and rdata<owner> = ram_doutb for one cycle, then move to IDLE.
REQ-024 Latency, with req first sampled in cycle N:
- gnt in cycle N+1.
- write lands at edge ending N+1.
- rvalid in cycle N+2.
REQ-025 Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-026 A requester SHALL hold req and payload stable until it sees gnt, then drop req no later than the next edge; a req still high in IDLE is a new request.
REQ-027 A write with be = 0000 SHALL be granted and complete with no RAM byte modified.
REQ-028 Requests arriving outside IDLE SHALL be ignored until IDLE, with no loss if still asserted.
REQ-029 With both req high in IDLE, the winner SHALL be chosen per REQ-035/036.

Reset
REQ-030 RSTn low SHALL asynchronously force IDLE, owner = 0, last-winner = 1, and all latched payload = 0.
REQ-031 While RSTn is low, gnt0/1, rvalid0/1, busy and ram_wea SHALL be 0.
REQ-032 Reset during ACCESS SHALL suppress the write, and no rvalid SHALL follow.
REQ-033 The first cycle after reset release is IDLE.

Configuration
REQ-034 Macro BRAM_ARB_RR_EN selects the arbitration policy.
REQ-035 With BRAM_ARB_RR_EN defined: round-robin.
- On contention, grant the requester that is not last-winner.
- last-winner updates on every grant.
REQ-036 Without BRAM_ARB_RR_EN: fixed priority, requester 0 always wins contention, and no last-winner register is built.

Structure
REQ-037 Shared package bram_arb_pkg SHALL hold:
- the FSM state typedef (IDLE/ACCESS/RDATA);
- NUM_REQ = 2;
- DATA_W = 32;
- BE_W = 4.
REQ-038 Winner selection SHALL be a sub-module bram_arb_pick with inputs req[1:0] and last-winner, and a one-hot winner output; the macro acts only inside it.

Verification
REQ-039 Write after reset: req0, we0=1, addr0=0x0010, wdata0=0xDEADBEEF, be0=F.
- gnt0 in cycle N+1, ram_wea=F in that same cycle, then busy=0 in cycle N+2.
- A following read of 0x0010 gives rvalid0 with rdata0=0xDEADBEEF, 2 cycles after its req.
REQ-040 Byte write: pre-load 0x11223344, then write wdata=0xAABBCCDD with be=0101.
- Readback SHALL be 0x11BB33DD.
REQ-041 Contention: req0 and req1 held high continuously for 4 grants.
- With RR_EN: grants alternate 0,1,0,1 (last-winner=1 after reset).
- Without RR_EN: requester 1 is never granted while req0 is held.
REQ-042 Reset mid-operation: RSTn low during the ACCESS cycle of a write of 0xCAFEF00D to 0x0020.
- Outputs clear immediately; the location keeps its old value; no rvalid follows.
REQ-043 Late request: req1 read asserted during requester 0's ACCESS.
- Serviced only after IDLE: gnt1 two cycles after requester 0's RDATA/IDLE, rdata1 correct, no duplicate grant to requester 0.
